// File: rtl/shake_pkg.sv
// Shared types and constants for the SHAKE128/256 sponge controller.
// The controller sequences absorb, permute and squeeze for an external Keccak datapath.
package shake_pkg;

    localparam int RATE128_LANES = 21;
    localparam int RATE256_LANES = 17;
    localparam int NUM_ROUNDS    = 24;
    localparam int LANE_W        = 64;

    localparam int LANE_IDX_W  = 5;
    localparam int ROUND_W     = 5;
    localparam int OUT_WORDS_W = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ABSORB  = 2'd1,
        PERMUTE = 2'd2,
        SQUEEZE = 2'd3
    } state_e;

    typedef enum logic {
        SHAKE128 = 1'b0,
        SHAKE256 = 1'b1
    } mode_e;

    localparam logic [ROUND_W-1:0] LAST_ROUND = ROUND_W'(NUM_ROUNDS - 1);

    // Index of the final lane of one rate block for the selected variant.
    function automatic logic [LANE_IDX_W-1:0] last_lane(input mode_e m);
        return (m == SHAKE256) ? LANE_IDX_W'(RATE256_LANES - 1)
                               : LANE_IDX_W'(RATE128_LANES - 1);
    endfunction

endpackage

// File: rtl/shake_ctrl_if.sv
// Control/handshake bundle between a sponge host (master) and shake_ctrl (slave).
// The slave side also drives the datapath strobes (state_clr, absorb_en, round_en).
interface shake_ctrl_if;
    import shake_pkg::*;

    logic                   start;
    logic                   mode;
    logic [OUT_WORDS_W-1:0] out_words;

    logic                   in_valid;
    logic                   in_ready;
    logic                   in_last;

    logic                   out_valid;
    logic                   out_ready;
    logic                   out_last;

    logic                   state_clr;
    logic                   absorb_en;
    logic [LANE_IDX_W-1:0]  lane_idx;
    logic                   round_en;
    logic [ROUND_W-1:0]     round_idx;

    logic                   busy;
    logic                   done;
    logic                   err;

    modport master (
        output start, mode, out_words, in_valid, in_last, out_ready,
        input  in_ready, out_valid, out_last, state_clr, absorb_en, lane_idx,
               round_en, round_idx, busy, done, err
    );

    modport slave (
        input  start, mode, out_words, in_valid, in_last, out_ready,
        output in_ready, out_valid, out_last, state_clr, absorb_en, lane_idx,
               round_en, round_idx, busy, done, err
    );

endinterface

// File: rtl/shake_round_cnt.sv
// Keccak round counter: steps 0..NUM_ROUNDS-1 while enabled and wraps to 0,
// so it always rests at 0 between permutations.
module shake_round_cnt
    import shake_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               en,
    output logic [ROUND_W-1:0] idx,
    output logic               last
);

    logic [ROUND_W-1:0] idx_q;

    // NOTE: sequential state is written with non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            idx_q <= '0;
        end else if (en) begin
            idx_q <= last ? '0 : idx_q + 1'b1;
        end
    end

    assign idx  = idx_q;
    assign last = (idx_q == LAST_ROUND);

endmodule

// File: rtl/shake_ctrl.sv
// SHAKE sponge sequencer: counts absorbed lanes, runs 24-round permutations and
// streams the requested number of output lanes, re-permuting at each rate boundary.
module shake_ctrl
    import shake_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    shake_ctrl_if.slave bus
);

    state_e                 state_q;
    mode_e                  mode_q;
    logic [OUT_WORDS_W-1:0] out_words_q;
    logic [OUT_WORDS_W-1:0] words_left_q;
    logic [LANE_IDX_W-1:0]  lane_cnt_q;
    logic                   last_blk_q;
    logic                   sq_phase_q;
    logic                   err_q;
    logic                   done_q;

    logic [ROUND_W-1:0]     rnd_idx;
    logic                   rnd_last;
    logic [LANE_IDX_W-1:0]  lane_max;

    assign lane_max = last_lane(mode_q);

    shake_round_cnt u_round_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (state_q != PERMUTE),
        .en   (state_q == PERMUTE),
        .idx  (rnd_idx),
        .last (rnd_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            mode_q       <= SHAKE128;
            out_words_q  <= '0;
            words_left_q <= '0;
            lane_cnt_q   <= '0;
            last_blk_q   <= 1'b0;
            sq_phase_q   <= 1'b0;
            err_q        <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        mode_q      <= mode_e'(bus.mode);
                        out_words_q <= bus.out_words;
                        err_q       <= 1'b0;
                        lane_cnt_q  <= '0;
                        sq_phase_q  <= 1'b0;
                        state_q     <= ABSORB;
                    end
                end
                ABSORB: begin
                    if (bus.in_valid) begin
                        if (lane_cnt_q == lane_max) begin
                            last_blk_q <= bus.in_last;
                            sq_phase_q <= 1'b0;
                            lane_cnt_q <= '0;
                            state_q    <= PERMUTE;
                        end else if (bus.in_last) begin
                            // Final word short of a full block: padding was wrong.
                            err_q      <= 1'b1;
                            lane_cnt_q <= '0;
                            state_q    <= IDLE;
                        end else begin
                            lane_cnt_q <= lane_cnt_q + 1'b1;
                        end
                    end
                end
                PERMUTE: begin
                    if (rnd_last) begin
                        lane_cnt_q <= '0;
                        if (sq_phase_q) begin
                            state_q <= SQUEEZE;
                        end else if (!last_blk_q) begin
                            state_q <= ABSORB;
                        end else if (out_words_q == '0) begin
                            done_q  <= 1'b1;
                            state_q <= IDLE;
                        end else begin
                            words_left_q <= out_words_q;
                            state_q      <= SQUEEZE;
                        end
                    end
                end
                SQUEEZE: begin
                    if (bus.out_ready) begin
                        words_left_q <= words_left_q - 1'b1;
                        if (words_left_q == OUT_WORDS_W'(1)) begin
                            done_q     <= 1'b1;
                            lane_cnt_q <= '0;
                            state_q    <= IDLE;
                        end else if (lane_cnt_q == lane_max) begin
                            sq_phase_q <= 1'b1;
                            lane_cnt_q <= '0;
                            state_q    <= PERMUTE;
                        end else begin
                            lane_cnt_q <= lane_cnt_q + 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    logic                  state_clr;
    logic                  absorb_en;
    logic                  in_ready;
    logic                  out_valid;
    logic                  out_last;
    logic                  round_en;
    logic [ROUND_W-1:0]    round_idx;
    logic [LANE_IDX_W-1:0] lane_idx;

    always_comb begin
        // NOTE: every output gets a default first so no path leaves one unassigned (no latches).
        state_clr = 1'b0;
        absorb_en = 1'b0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        round_en  = 1'b0;
        round_idx = '0;
        lane_idx  = '0;
        unique case (state_q)
            IDLE: begin
                state_clr = bus.start;
            end
            ABSORB: begin
                in_ready  = 1'b1;
                absorb_en = bus.in_valid;
                lane_idx  = lane_cnt_q;
            end
            PERMUTE: begin
                round_en  = 1'b1;
                round_idx = rnd_idx;
            end
            SQUEEZE: begin
                out_valid = 1'b1;
                lane_idx  = lane_cnt_q;
                out_last  = (words_left_q == OUT_WORDS_W'(1));
            end
            default: ;
        endcase
    end

    assign bus.state_clr = state_clr;
    assign bus.absorb_en = absorb_en;
    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_last  = out_last;
    assign bus.round_en  = round_en;
    assign bus.round_idx = round_idx;
    assign bus.lane_idx  = lane_idx;
    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = done_q;
    assign bus.err       = err_q;

endmodule

// File: tb/tb_shake_ctrl.sv
// Directed scenarios for shake_ctrl; inputs change on the falling edge and
// outputs are sampled 1 ns later, half a period away from the active edge.
module tb_shake_ctrl;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    shake_ctrl_if bus ();

    shake_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // All controller outputs packed; zero whenever the block is idle and quiet.
    function automatic logic [18:0] outs();
        return {bus.state_clr, bus.absorb_en, bus.in_ready, bus.out_valid, bus.out_last,
                bus.round_en, bus.busy, bus.done, bus.err, bus.lane_idx, bus.round_idx};
    endfunction

    task automatic clear_inputs();
        bus.start     = 1'b0;
        bus.mode      = 1'b0;
        bus.out_words = '0;
        bus.in_valid  = 1'b0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        clear_inputs();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic start_hash(input logic m, input logic [15:0] w);
        @(negedge clk);
        bus.start     = 1'b1;
        bus.mode      = m;
        bus.out_words = w;
        @(posedge clk);
        #1 bus.start = 1'b0;
    endtask

    // Offers n contiguous words (one block at most); in_last optionally on the final one.
    task automatic feed(input int n, input bit last_on_final);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.in_last  = last_on_final && (i == n - 1);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++;
        if (outs() !== 19'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %0h expected 0", outs());
        end
    endtask

    task automatic test_shake128();
        @(negedge clk);
        bus.start = 1'b1; bus.mode = 1'b0; bus.out_words = 16'd2;
        #1;
        n_checks++;
        if ({bus.state_clr, bus.busy} !== 2'b10) begin
            n_fail++;
            $display("FAIL s128_state_clr: got %b expected 10", {bus.state_clr, bus.busy});
        end
        @(posedge clk);
        #1 bus.start = 1'b0;
        for (int i = 0; i < 21; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.in_last  = (i == 20);
            #1;
            n_checks++;
            if ({bus.absorb_en, bus.in_ready, bus.lane_idx} !== {2'b11, 5'(i)}) begin
                n_fail++;
                $display("FAIL s128_absorb[%0d]: got %0h expected %0h", i,
                         {bus.absorb_en, bus.in_ready, bus.lane_idx}, {2'b11, 5'(i)});
            end
        end
        @(negedge clk);
        bus.in_valid = 1'b0; bus.in_last = 1'b0;
        for (int r = 0; r < 24; r++) begin
            if (r != 0) @(negedge clk);
            #1;
            n_checks++;
            if ({bus.round_en, bus.round_idx, bus.in_ready, bus.out_valid, bus.lane_idx}
                !== {1'b1, 5'(r), 2'b00, 5'd0}) begin
                n_fail++;
                $display("FAIL s128_round[%0d]: got en=%b idx=%0d rdy=%b ov=%b expected en=1 idx=%0d",
                         r, bus.round_en, bus.round_idx, bus.in_ready, bus.out_valid, r);
            end
        end
        for (int w = 0; w < 2; w++) begin
            @(negedge clk);
            bus.out_ready = 1'b1;
            #1;
            n_checks++;
            if ({bus.out_valid, bus.lane_idx, bus.out_last, bus.round_en}
                !== {1'b1, 5'(w), (w == 1), 1'b0}) begin
                n_fail++;
                $display("FAIL s128_squeeze[%0d]: got ov=%b lane=%0d last=%b expected ov=1 lane=%0d last=%b",
                         w, bus.out_valid, bus.lane_idx, bus.out_last, w, (w == 1));
            end
        end
        @(negedge clk);
        bus.out_ready = 1'b0;
        #1;
        n_checks++;
        if ({bus.done, bus.busy, bus.out_valid, bus.err} !== 4'b1000) begin
            n_fail++;
            $display("FAIL s128_done: got %b expected 1000", {bus.done, bus.busy, bus.out_valid, bus.err});
        end
        @(negedge clk);
        #1;
        n_checks++;
        if (bus.done !== 1'b0) begin
            n_fail++;
            $display("FAIL s128_done_pulse: got %b expected 0", bus.done);
        end
    endtask

    task automatic test_two_blocks();
        int gap;
        int rounds;
        int done_at;
        bit ov_seen;
        start_hash(1'b1, 16'd0);
        for (int k = 0; k < 34; k++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.in_last  = (k == 33);
            #1;
            gap = 0;
            while (!bus.in_ready && gap < 60) begin
                gap++;
                @(negedge clk);
                #1;
            end
            n_checks++;
            if ({gap, bus.absorb_en, bus.lane_idx} !== {((k == 17) ? 24 : 0), 1'b1, 5'(k % 17)}) begin
                n_fail++;
                $display("FAIL s256_word[%0d]: got gap=%0d ae=%b lane=%0d expected gap=%0d ae=1 lane=%0d",
                         k, gap, bus.absorb_en, bus.lane_idx, (k == 17) ? 24 : 0, k % 17);
            end
        end
        rounds = 0; done_at = 0; ov_seen = 1'b0;
        @(posedge clk);
        #1 bus.in_valid = 1'b0; bus.in_last = 1'b0;
        for (int j = 1; j <= 40 && done_at == 0; j++) begin
            @(negedge clk);
            #1;
            if (bus.round_en) rounds++;
            if (bus.out_valid) ov_seen = 1'b1;
            if (bus.done) done_at = j;
        end
        n_checks++;
        if ({rounds, done_at, ov_seen} !== {32'd24, 32'd25, 1'b0}) begin
            n_fail++;
            $display("FAIL s256_second_perm: got rounds=%0d done_at=%0d ov=%b expected 24 25 0",
                     rounds, done_at, ov_seen);
        end
    endtask

    task automatic test_multi_squeeze();
        int o;
        int rnd;
        bit done_seen;
        start_hash(1'b1, 16'd20);
        feed(17, 1'b1);
        o = 0; rnd = 0; done_seen = 1'b0;
        for (int j = 0; j < 200 && !done_seen; j++) begin
            @(negedge clk);
            bus.out_ready = 1'b1;
            #1;
            if (bus.round_en && !bus.out_valid) rnd++;
            if (bus.out_valid) begin
                n_checks++;
                if ({bus.lane_idx, bus.out_last, rnd}
                    !== {5'((o < 17) ? o : o - 17), (o == 19), ((o == 0 || o == 17) ? 24 : 0)}) begin
                    n_fail++;
                    $display("FAIL multi_out[%0d]: got lane=%0d last=%b gap=%0d expected lane=%0d last=%b gap=%0d",
                             o, bus.lane_idx, bus.out_last, rnd, (o < 17) ? o : o - 17, (o == 19),
                             (o == 0 || o == 17) ? 24 : 0);
                end
                rnd = 0;
                o++;
            end
            if (bus.done) done_seen = 1'b1;
        end
        bus.out_ready = 1'b0;
        n_checks++;
        if ({o, done_seen} !== {32'd20, 1'b1}) begin
            n_fail++;
            $display("FAIL multi_count: got outputs=%0d done=%b expected 20 1", o, done_seen);
        end
    endtask

    task automatic test_pad_error();
        int rounds;
        int dones;
        start_hash(1'b0, 16'd4);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.in_last  = (i == 4);
        end
        #1;
        n_checks++;
        if ({bus.absorb_en, bus.lane_idx} !== {1'b1, 5'd4}) begin
            n_fail++;
            $display("FAIL pad_last_absorb: got ae=%b lane=%0d expected ae=1 lane=4", bus.absorb_en, bus.lane_idx);
        end
        @(negedge clk);
        bus.in_valid = 1'b0; bus.in_last = 1'b0;
        #1;
        n_checks++;
        if ({bus.err, bus.busy, bus.done} !== 3'b100) begin
            n_fail++;
            $display("FAIL pad_err: got %b expected 100", {bus.err, bus.busy, bus.done});
        end
        rounds = 0; dones = 0;
        for (int j = 0; j < 30; j++) begin
            @(negedge clk);
            #1;
            if (bus.round_en) rounds++;
            if (bus.done) dones++;
        end
        n_checks++;
        if ({rounds, dones, bus.err} !== {32'd0, 32'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL pad_quiet: got rounds=%0d dones=%0d err=%b expected 0 0 1", rounds, dones, bus.err);
        end
        start_hash(1'b0, 16'd1);
        #1;
        n_checks++;
        if ({bus.err, bus.busy} !== 2'b01) begin
            n_fail++;
            $display("FAIL pad_err_clear: got %b expected 01", {bus.err, bus.busy});
        end
        apply_reset();
    endtask

    task automatic test_backpressure_reset();
        int wait_cnt;
        bit found;
        bit rdy[8]   = '{1, 0, 0, 0, 1, 1, 1, 1};
        int lanes[8] = '{0, 1, 1, 1, 1, 2, 3, 4};
        start_hash(1'b0, 16'd5);
        feed(21, 1'b1);
        wait_cnt = 0;
        @(negedge clk);
        #1;
        while (!bus.out_valid && wait_cnt < 60) begin
            wait_cnt++;
            @(negedge clk);
            #1;
        end
        n_checks++;
        if (wait_cnt !== 24) begin
            n_fail++;
            $display("FAIL bp_latency: got %0d expected 24", wait_cnt);
        end
        for (int c = 0; c < 8; c++) begin
            if (c != 0) @(negedge clk);
            bus.out_ready = rdy[c];
            #1;
            n_checks++;
            if ({bus.out_valid, bus.lane_idx, bus.out_last} !== {1'b1, 5'(lanes[c]), (c == 7)}) begin
                n_fail++;
                $display("FAIL bp_cycle[%0d]: got ov=%b lane=%0d last=%b expected ov=1 lane=%0d last=%b",
                         c, bus.out_valid, bus.lane_idx, bus.out_last, lanes[c], (c == 7));
            end
        end
        @(negedge clk);
        bus.out_ready = 1'b0;
        #1;
        n_checks++;
        if ({bus.done, bus.busy} !== 2'b10) begin
            n_fail++;
            $display("FAIL bp_done: got %b expected 10", {bus.done, bus.busy});
        end
        start_hash(1'b1, 16'd1);
        feed(17, 1'b0);
        found = 1'b0;
        for (int j = 0; j < 40 && !found; j++) begin
            @(negedge clk);
            #1;
            if (bus.round_en && bus.round_idx == 5'd10) found = 1'b1;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++;
        if ({found, outs()} !== {1'b1, 19'd0}) begin
            n_fail++;
            $display("FAIL mid_perm_reset: got found=%b outs=%0h expected found=1 outs=0", found, outs());
        end
    endtask

    task automatic test_zero_out();
        int done_at;
        bit ov_seen;
        start_hash(1'b0, 16'd0);
        feed(21, 1'b1);
        done_at = 0; ov_seen = 1'b0;
        for (int k = 1; k <= 40 && done_at == 0; k++) begin
            @(negedge clk);
            bus.start = (k == 5);
            bus.mode  = (k == 5);
            #1;
            if (bus.out_valid) ov_seen = 1'b1;
            if (bus.done) done_at = k;
        end
        bus.start = 1'b0; bus.mode = 1'b0;
        n_checks++;
        if ({done_at, ov_seen, bus.busy} !== {32'd25, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL zero_out: got done_at=%0d ov=%b busy=%b expected 25 0 0", done_at, ov_seen, bus.busy);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_shake128();
        test_two_blocks();
        test_multi_squeeze();
        test_pad_error();
        test_backpressure_reset();
        test_zero_out();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/shake_ctrl.md
SHAKE_CTRL -- requirements
Module: shake_ctrl

Interface
REQ-001 The module SHALL have no parameters; all sizes come from shake_pkg.
REQ-002 clk  in  1  single clock; all state updates on its rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 start  in  1  one-cycle request to begin a hash; honoured only in IDLE.
REQ-005 mode  in  1  0 = SHAKE128 (rate 21 lanes), 1 = SHAKE256 (rate 17 lanes); sampled at start.
REQ-006 out_words  in  16  number of 64-bit output words requested; sampled at start.
REQ-007 in_valid / in_ready / in_last  in/out/in  1 each  absorb handshake; words arrive pre-padded; in_last marks the final word.
REQ-008 out_valid / out_ready / out_last  out/in/out  1 each  squeeze handshake; out_last marks the final requested word.
REQ-009 state_clr  out  1  clears the datapath Keccak state register.
REQ-010 absorb_en  out  1  XORs the input word into lane lane_idx.
REQ-011 lane_idx  out  5  lane selected for absorb or squeeze.
REQ-012 round_en / round_idx  out  1 / 5  enables one Keccak round and selects round constant 0..23.
REQ-013 busy / done / err  out  1 each  not-IDLE / one-cycle completion pulse / sticky padding error.

Function
REQ-014 The FSM SHALL have exactly four states: IDLE, ABSORB, PERMUTE, SQUEEZE.
REQ-015 IDLE: if start=1, latch mode and out_words, assert state_clr for that cycle, clear err, set lane_cnt=0, and go to ABSORB.
REQ-016 ABSORB: in_ready=1; on in_valid&in_ready, absorb_en=1 combinationally, lane_idx=lane_cnt, and lane_cnt increments.
REQ-017 On a handshake at lane_cnt=rate-1, go to PERMUTE and record last_blk=in_last.
REQ-018 On a handshake with in_last=1 and lane_cnt!=rate-1, still pulse absorb_en, set err=1, and return to IDLE without permuting or pulsing done.
REQ-019 PERMUTE: round_en=1 for exactly 24 consecutive cycles with round_idx 0,1,...,23; in_ready=0 and out_valid=0 throughout.
REQ-020 After round 23 in the absorb phase with last_blk=0, go to ABSORB with lane_cnt=0.
REQ-021 After round 23 in the absorb phase with last_blk=1: if out_words=0, pulse done and go to IDLE; otherwise go to SQUEEZE with lane_cnt=0 and words_left=out_words.
REQ-022 SQUEEZE: out_valid=1, lane_idx=lane_cnt, and out_last=(words_left==1).
REQ-023 On each out handshake in SQUEEZE, words_left decrements and lane_cnt increments.
REQ-024 When the handshake has words_left=1, pulse done on the next cycle and go to IDLE; else if lane_cnt=rate-1, go to PERMUTE (squeeze phase) and then back to SQUEEZE with lane_cnt=0.
REQ-025 When out_ready=0, out_valid, lane_idx and words_left SHALL be held unchanged.
REQ-026 Latency: the last rate-boundary handshake at cycle t gives round_en in cycles t+1..t+24, and in_ready or out_valid at t+25.
REQ-027 start outside IDLE SHALL be ignored; busy=1 in every state except IDLE.
REQ-028 Outputs not named as active in a state SHALL be 0, and lane_idx SHALL be 0 outside ABSORB and SQUEEZE.

Reset
REQ-029 rst=1 at any cycle, including mid-PERMUTE or mid-SQUEEZE, SHALL return the FSM to IDLE at the next edge.
REQ-030 That reset SHALL zero lane_cnt, round counter, words_left, latched mode, err and all outputs; the reset value of every output is 0.

Structure
REQ-031 shake_pkg SHALL hold the state enum, RATE128_LANES=21, RATE256_LANES=17, NUM_ROUNDS=24 and LANE_W=64.
REQ-032 The 5-bit round counter SHALL be a sub-module shake_round_cnt, with ports clr, en, idx and last.

Verification
REQ-033 SHAKE128, 21 words with in_last on word 21, out_words=2: absorb_en on lanes 0..20; round_idx 0..23; out words on lanes 0,1 with out_last on the 2nd; then a done pulse.
REQ-034 SHAKE256, 34 words: two PERMUTE passes; in_ready=0 for exactly the 24 cycles between word 17 and word 18.
REQ-035 SHAKE256, 17 words, out_words=20: 17 outputs, a 24-cycle gap with out_valid=0 and round_en=1, then 3 outputs on lanes 0..2.
REQ-036 SHAKE128 with in_last on word 5: err=1, return to IDLE, round_en never asserted, no done pulse.
REQ-037 out_ready held low for 3 cycles mid-squeeze: lane_idx and out_valid stable; rst asserted at round_idx=10: all outputs 0 next cycle and busy=0.
REQ-038 out_words=0 with a single block: a done pulse 25 cycles after the last handshake, and out_valid never asserted.
